// File: rtl/speaker_ctl_pkg.sv
// Shared constants and types for the I2S speaker controller.
// All divider taps come from a single free-running 9-bit frame counter.
package speaker_ctl_pkg;

    localparam int unsigned SCK_DIV    = 16;
    localparam int unsigned FRAME_CLKS = 512;
    localparam int unsigned MCLK_BIT   = 1;
    localparam int unsigned SCK_BIT    = 3;
    localparam int unsigned LRCK_BIT   = 8;
    localparam int unsigned LATCH_CNT  = FRAME_CLKS - 1;

    typedef logic [15:0] sample_t;

    function automatic sample_t mute_gate(input sample_t s, input logic mute);
        return mute ? '0 : s;
    endfunction

endpackage

// File: rtl/speaker_ctl_if.sv
// Sample-in / I2S-out bundle between the tone generator, the controller and the DAC pins.
interface speaker_ctl_if #(
    parameter int unsigned SAMPLE_W = 16
);

    logic [SAMPLE_W-1:0] audio_left;
    logic [SAMPLE_W-1:0] audio_right;
    logic                mute;
    logic                audio_mclk;
    logic                audio_lrck;
    logic                audio_sck;
    logic                audio_sdin;
    logic                sample_tick;

    modport master (
        output audio_left, audio_right, mute,
        input  audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick
    );

    modport slave (
        input  audio_left, audio_right, mute,
        output audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick
    );

endinterface

// File: rtl/speaker_clk_gen.sv
// Frame counter for the I2S link: MCLK/SCK/LRCK are raw counter bits, plus
// the once-per-frame latch strobe and the end-of-slot strobe.
module speaker_clk_gen
    import speaker_ctl_pkg::*;
#(
    parameter int unsigned CNT_W = 9
) (
    input  logic clk,
    input  logic rst_n,
    output logic mclk,
    output logic sck,
    output logic lrck,
    output logic latch,
    output logic slot_end
);

    localparam int unsigned SLOT_W = $clog2(SCK_DIV);

    logic [CNT_W-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign mclk     = div_cnt[MCLK_BIT];
    assign sck      = div_cnt[SCK_BIT];
    assign lrck     = div_cnt[LRCK_BIT];
    assign latch    = (div_cnt == CNT_W'(LATCH_CNT));
    assign slot_end = (div_cnt[SLOT_W-1:0] == '1);

endmodule

// File: rtl/speaker_ctl.sv
// Latches one stereo sample pair per 512-clk frame and serialises it as
// I2S (MSB first, one-slot delay) towards the external DAC.
module speaker_ctl
    import speaker_ctl_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned CNT_W    = 9
) (
    input  logic clk,
    input  logic rst_n,
    speaker_ctl_if.slave bus
);

    localparam int unsigned FRAME_W = 2 * SAMPLE_W;

    logic               latch;
    logic               slot_end;
    logic [FRAME_W-1:0] shreg;
    logic               sdin;

    speaker_clk_gen #(
        .CNT_W (CNT_W)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .mclk     (bus.audio_mclk),
        .sck      (bus.audio_sck),
        .lrck     (bus.audio_lrck),
        .latch    (latch),
        .slot_end (slot_end)
    );

    // At the latch edge the shifter has been shifted 31 times, so its MSB is
    // the previous frame's right LSB: that bit lands in slot 0 while the new
    // pair is loaded, which is exactly the I2S one-slot delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            sdin  <= 1'b0;
        end else if (slot_end) begin
            sdin <= shreg[FRAME_W-1];
            if (latch) begin
                shreg <= {mute_gate(bus.audio_left, bus.mute),
                          mute_gate(bus.audio_right, bus.mute)};
            end else begin
                shreg <= {shreg[FRAME_W-2:0], 1'b0};
            end
        end
    end

    assign bus.audio_sdin  = sdin;
    assign bus.sample_tick = latch;

endmodule

// File: tb/tb_speaker_ctl.sv
// Directed bench for speaker_ctl: clock ratios, frame contents from a vector
// table, and hand sequences for mid-frame input change and mid-frame reset.
module tb_speaker_ctl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    speaker_ctl_if #(.SAMPLE_W(16)) bus ();

    speaker_ctl #(
        .SAMPLE_W (16),
        .CNT_W    (9)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
        logic        mute;
        logic        exp_s0;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Returns on the negedge where sample_tick is high (div_cnt == 511).
    task automatic wait_tick(input string name);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.sample_tick !== 1'b1 && n < 1000);
        check({name, " tick timeout"}, (n < 1000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Called on the tick negedge; samples sdin mid-slot (SCK high) for slots 0..31.
    task automatic capture_frame(output logic [31:0] w, output logic tick_seen,
                                 input logic chg_en, input logic [15:0] chg_val);
        w = '0;
        tick_seen = 1'b0;
        for (int n = 0; n <= 504; n++) begin
            @(negedge clk);
            if (bus.sample_tick === 1'b1) tick_seen = 1'b1;
            if (n % 16 == 8) w[31 - n / 16] = bus.audio_sdin;
            if (chg_en && n == 100) bus.audio_left = chg_val;
        end
    endtask

    initial begin
        logic [31:0] fw [4];
        logic [31:0] w;
        logic [31:0] nb;
        logic        ts;
        int unsigned e_mclk, e_sck, e_lrck, e_tick, e_sdin0, e_sdin, n_tick, first_tick;

        vecs[0] = '{16'h1234, 16'h5678, 1'b1, 1'b1, 16'h0000, 16'h0000};
        vecs[1] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h1234, 16'h5678};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 16'h0001};
        vecs[3] = '{16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h7FFF, 16'h0000};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 16'h0001};
        vecs[5] = '{16'h8000, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 16'hFFFF};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000};

        fw[0] = 32'h0;
        fw[1] = {1'b0, 16'hA5C3, 15'h0787};
        fw[2] = {1'b1, 16'hA5C3, 15'h0787};
        fw[3] = {1'b1, 16'hA5C3, 15'h0787};

        bus.audio_left  = 16'hA5C3;
        bus.audio_right = 16'h0F0F;
        bus.mute        = 1'b0;

        repeat (3) @(negedge clk);
        check("reset mclk", {31'b0, bus.audio_mclk}, 32'd0);
        check("reset sck",  {31'b0, bus.audio_sck},  32'd0);
        check("reset lrck", {31'b0, bus.audio_lrck}, 32'd0);
        check("reset sdin", {31'b0, bus.audio_sdin}, 32'd0);
        check("reset tick", {31'b0, bus.sample_tick}, 32'd0);

        // After n posedges past release the frame counter should read n mod 512.
        rst_n = 1'b1;
        e_mclk = 0; e_sck = 0; e_lrck = 0; e_tick = 0; e_sdin0 = 0; e_sdin = 0; n_tick = 0;
        for (int n = 1; n <= 2048; n++) begin
            @(negedge clk);
            nb = n;
            if (bus.audio_mclk !== nb[1]) e_mclk++;
            if (bus.audio_sck  !== nb[3]) e_sck++;
            if (bus.audio_lrck !== nb[8]) e_lrck++;
            if (bus.sample_tick !== (nb[8:0] == 9'h1FF)) e_tick++;
            if (bus.sample_tick === 1'b1) n_tick++;
            if (nb[3:0] == 4'd8 && n < 2048) begin
                w = fw[n / 512];
                if (bus.audio_sdin !== w[31 - nb[8:4]]) begin
                    if (n < 512) e_sdin0++;
                    else e_sdin++;
                end
            end
        end
        check("mclk pattern errors", e_mclk, 0);
        check("sck pattern errors",  e_sck,  0);
        check("lrck pattern errors", e_lrck, 0);
        check("tick position errors", e_tick, 0);
        check("tick count in 2048", n_tick, 4);
        check("first frame zero errors", e_sdin0, 0);
        check("A5C3/0F0F stream errors", e_sdin, 0);

        for (int i = 0; i < 7; i++) begin
            bus.audio_left  = vecs[i].left;
            bus.audio_right = vecs[i].right;
            bus.mute        = vecs[i].mute;
            wait_tick($sformatf("vec%0d", i));
            capture_frame(w, ts, 1'b0, 16'h0);
            check($sformatf("vec%0d frame", i), w,
                  {vecs[i].exp_s0, vecs[i].exp_l, vecs[i].exp_r[15:1]});
            check($sformatf("vec%0d single tick", i), {31'b0, ts}, 32'd0);
        end

        // Left word changes at div_cnt==100: frame in flight must keep 7FFF.
        bus.audio_left  = 16'h7FFF;
        bus.audio_right = 16'h0000;
        wait_tick("midchg");
        capture_frame(w, ts, 1'b1, 16'h8000);
        check("midchg frame in flight", w, {1'b0, 16'h7FFF, 15'h0});
        wait_tick("midchg next");
        capture_frame(w, ts, 1'b0, 16'h0);
        check("midchg next frame", w, {1'b0, 16'h8000, 15'h0});

        // Reset asserted at div_cnt==300 (slot 18 of an all-ones frame).
        bus.audio_left  = 16'hFFFF;
        bus.audio_right = 16'hFFFF;
        wait_tick("prereset");
        repeat (301) @(negedge clk);
        check("pre-reset sdin", {31'b0, bus.audio_sdin}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("in-reset outputs",
              {27'b0, bus.audio_mclk, bus.audio_sck, bus.audio_lrck, bus.audio_sdin, bus.sample_tick},
              32'd0);
        bus.audio_left  = 16'hA5C3;
        bus.audio_right = 16'h0F0F;
        repeat (3) @(negedge clk);
        check("held-reset outputs",
              {27'b0, bus.audio_mclk, bus.audio_sck, bus.audio_lrck, bus.audio_sdin, bus.sample_tick},
              32'd0);
        rst_n = 1'b1;
        first_tick = 0;
        e_sdin0 = 0;
        for (int n = 1; n <= 511; n++) begin
            @(negedge clk);
            nb = n;
            if (bus.sample_tick === 1'b1 && first_tick == 0) first_tick = n;
            if (nb[3:0] == 4'd8 && bus.audio_sdin !== 1'b0) e_sdin0++;
        end
        check("post-reset first tick", first_tick, 511);
        check("post-reset zero frame errors", e_sdin0, 0);
        capture_frame(w, ts, 1'b0, 16'h0);
        check("post-reset second frame", w, {1'b0, 16'hA5C3, 15'h0787});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
